vga_feed: RTL and testbench
===========================

VGA_FEED -- requirements
Module: vga_feed

Interface
- REQ-001 The block SHALL take parameter h, default 1920, meaning active pixels per line; h SHALL be even.
- REQ-002 The block SHALL take parameter v, default 1080, meaning active lines per frame.
- REQ-003 The block SHALL take parameter n, default 32, meaning pixel-pair data width.
- REQ-004 The block SHALL take parameter lat, default 1 (range 1..4), meaning generator cycles from cke high to valid d.
- REQ-005 The block SHALL take parameter hi, default 12, meaning the fill level at which feeding stops.
- REQ-006 The block SHALL take parameter lo, default 4, meaning the fill level at which feeding resumes; lo < hi is required.
- REQ-007 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
- REQ-008 The block SHALL have port rst, input, 1 bit, reset; rst is asynchronous and active-low.
- REQ-009 The block SHALL have port lvl, input, 4 bits, downstream FIFO coarse fill level, where 15 means full.
- REQ-010 The block SHALL have port d, input, n bits, the even/odd pixel pair from the test generator.
- REQ-011 The block SHALL have port cke, output, 1 bit, the generator clock enable.
- REQ-012 The block SHALL have port wd, output, n bits, the FIFO write data.
- REQ-013 The block SHALL have port we, output, 1 bit, the FIFO write strobe.
- REQ-014 The block SHALL have ports x and y, outputs, 11 bits each, the coordinates of the even pixel of wd.
- REQ-015 The block SHALL have ports sof and eol, outputs, 1 bit each, the start-of-frame and end-of-line markers, qualified by we.
- REQ-016 The block SHALL have port drop_cnt, output, 16 bits, the dropped-pair count.

Function
- REQ-017 The block SHALL implement a two-state FSM with states RUN and HOLD; cke is registered, 1 in RUN and 0 in HOLD.
- REQ-018 In RUN, lvl >= hi SHALL cause a move to HOLD, so cke is 0 from the next cycle.
- REQ-019 In HOLD, lvl <= lo SHALL cause a move to RUN, so cke is 1 from the next cycle; levels between lo and hi SHALL keep the current state.
- REQ-020 A lat-deep shift register of cke SHALL mark d valid exactly lat cycles after each cke=1 cycle; pairs in flight SHALL complete regardless of later HOLD.
- REQ-021 On a valid cycle with lvl < 15, d SHALL be registered into wd, with we=1 in the following cycle (cke-to-we latency lat+1); we SHALL be 0 otherwise and wd SHALL then hold its value.
- REQ-022 On every valid cycle, accepted or dropped, x SHALL advance by 2; at x = h-2 it SHALL wrap to 0 and y SHALL increment; at y = v-1 with x wrap, y SHALL wrap to 0.
- REQ-023 sof SHALL be 1 only when we=1, x=0 and y=0; eol SHALL be 1 only when we=1 and x=h-2.
- REQ-024 A valid cycle with lvl = 15 SHALL drop the pair: we=0, coordinates still advance, and drop_cnt increments, saturating at 65535.

Reset
- REQ-025 While rst=0, the block SHALL hold cke, we, sof, eol, wd, x, y and drop_cnt at 0, clear the valid pipeline, and set the state to RUN.
- REQ-026 On the first rising clk edge after rst is released, cke SHALL go to 1; a reset mid-line SHALL discard in-flight pairs and restart at x=0, y=0.

Configuration
- REQ-027 With macro VGA_FEED_DROP_CNT_EN defined, the counter SHALL be built as in REQ-024.
- REQ-028 Without VGA_FEED_DROP_CNT_EN, drop_cnt SHALL be tied to 0 and no counter SHALL be synthesized; drop behaviour (we=0, coordinates advance) SHALL be unchanged.

Verification (h=8, v=4, lat=1, hi=12, lo=4, unless stated)
- REQ-029 Holding rst=0 -> all outputs 0; releasing it with lvl=0 -> cke=1 at edge 1, first we=1 at edge 3 with x=0, y=0, sof=1.
- REQ-030 With lvl=0, 17 pairs -> x sequence 0,2,4,6 repeating, eol on each x=6, y steps 0..3, sof on pairs 1 and 17.
- REQ-031 Driving lvl=12 -> cke=0 next cycle; lvl=8 -> cke stays 0; lvl=4 -> cke=1 next cycle.
- REQ-032 With lat=2, cke dropping after 5 high cycles -> exactly 5 we pulses, the last two arriving after cke fell.
- REQ-033 With lvl=15 during 3 valid cycles -> no we for those cycles, x advances by 6, drop_cnt=3 (0 without the macro).
- REQ-034 Asserting rst at x=4 with 2 pairs in flight, then releasing it -> no stale we, and the next we carries x=0, y=0, sof=1.

Source files
------------

// File: rtl/vga_feed.sv
// vga_feed: moves pixel pairs from a test-pattern generator into a downstream
// FIFO. Generator flow is throttled with hysteresis on the FIFO's coarse fill
// level, and every pair is tagged with its frame coordinates.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous reset, active low
//   lvl[3:0]  downstream FIFO coarse fill level (15 = full)
//   d[n-1:0]  even/odd pixel pair from the generator
//   cke       registered generator clock enable
//   wd[n-1:0] FIFO write data (holds its value when we=0)
//   we        FIFO write strobe
//   x, y      coordinates of the even pixel carried by wd
//   sof, eol  start-of-frame / end-of-line markers, only high with we
//   drop_cnt  saturating count of pairs dropped because the FIFO was full
//
// Optional feature: define VGA_FEED_DROP_CNT_EN to build the drop counter.
// Without it drop_cnt is tied to zero; dropping behaviour is unchanged.
module vga_feed #(
    parameter int h   = 1920,
    parameter int v   = 1080,
    parameter int n   = 32,
    parameter int lat = 1,
    parameter int hi  = 12,
    parameter int lo  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   lvl,
    input  logic [n-1:0] d,
    output logic         cke,
    output logic [n-1:0] wd,
    output logic         we,
    output logic [10:0]  x,
    output logic [10:0]  y,
    output logic         sof,
    output logic         eol,
    output logic [15:0]  drop_cnt
);

    localparam logic [3:0]  HI_L   = 4'(hi);
    localparam logic [3:0]  LO_L   = 4'(lo);
    localparam logic [10:0] X_LAST = 11'(h - 2);
    localparam logic [10:0] Y_LAST = 11'(v - 1);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic           cke_q, cke_d;
    logic [lat-1:0] vpipe_q, vpipe_d;
    logic [10:0]    px_q, px_d;
    logic [10:0]    py_q, py_d;
    logic [n-1:0]   wd_q, wd_d;
    logic           we_q, we_d;
    logic [10:0]    x_q, x_d;
    logic [10:0]    y_q, y_d;
    logic           sof_q, sof_d;
    logic           eol_q, eol_d;

    logic valid;
    logic full;

    // The oldest pipeline stage is the cke issued lat cycles ago, so d is
    // meaningful this cycle exactly when that stage is set.
    assign valid = vpipe_q[lat-1];
    assign full  = (lvl == 4'hF);

    // Hysteresis: stop feeding at the high mark, resume only at the low mark.
    // cke follows the next state so it changes on the cycle after the decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (lvl >= HI_L) state_d = HOLD;
            HOLD:    if (lvl <= LO_L) state_d = RUN;
            default: state_d = RUN;
        endcase
        cke_d = (state_d == RUN);
    end

    // Delay line of cke; pairs already requested keep flowing through it
    // even after the FSM falls into HOLD.
    always_comb begin
        vpipe_d    = vpipe_q;
        vpipe_d[0] = cke_q;
        for (int i = 1; i < lat; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    // px/py track the position of the next pair to arrive. Every valid pair
    // consumes a position, even when it is dropped, so the picture stays
    // aligned. x/y/wd only load for accepted pairs so they always describe wd.
    always_comb begin
        px_d  = px_q;
        py_d  = py_q;
        wd_d  = wd_q;
        x_d   = x_q;
        y_d   = y_q;
        we_d  = 1'b0;
        sof_d = 1'b0;
        eol_d = 1'b0;
        if (valid) begin
            if (!full) begin
                wd_d  = d;
                we_d  = 1'b1;
                x_d   = px_q;
                y_d   = py_q;
                sof_d = (px_q == 11'd0) && (py_q == 11'd0);
                eol_d = (px_q == X_LAST);
            end
            if (px_q == X_LAST) begin
                px_d = 11'd0;
                py_d = (py_q == Y_LAST) ? 11'd0 : py_q + 11'd1;
            end else begin
                px_d = px_q + 11'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cke_q   <= 1'b0;
            vpipe_q <= '0;
            px_q    <= '0;
            py_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cke_q   <= cke_d;
            vpipe_q <= vpipe_d;
            px_q    <= px_d;
            py_q    <= py_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

`ifdef VGA_FEED_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturates instead of wrapping so a long overflow never reads as small.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (valid && full && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

    assign cke = cke_q;
    assign wd  = wd_q;
    assign we  = we_q;
    assign x   = x_q;
    assign y   = y_q;
    assign sof = sof_q;
    assign eol = eol_q;

endmodule

// File: tb/tb_vga_feed.sv
// Testbench for vga_feed: two instances (lat=1 and lat=2) share one stimulus
// stream and are each compared every cycle against a pair-level model.
module tb_vga_feed;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HI = 12;
    localparam int LO = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  lvl;
    logic [31:0] d;

    logic        cke_o  [2];
    logic [31:0] wd_o   [2];
    logic        we_o   [2];
    logic [10:0] x_o    [2];
    logic [10:0] y_o    [2];
    logic        sof_o  [2];
    logic        eol_o  [2];
    logic [15:0] drop_o [2];

    int vectors;
    int miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s[lat=%0d] at %0t: got %0h, expected %0h",
                     name, inst + 1, $time, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the falling edge, so the compare
    // processes (on the falling edge) and the DUT (on the rising edge) both
    // see stable values.
    task automatic applyStimulus(input logic [3:0] lv);
        @(negedge clk);
        #1;
        lvl = lv;
        d   = $urandom;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = g + 1;

        vga_feed #(
            .h(H), .v(V), .n(32), .lat(LAT), .hi(HI), .lo(LO)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .lvl(lvl),
            .d(d),
            .cke(cke_o[g]),
            .wd(wd_o[g]),
            .we(we_o[g]),
            .x(x_o[g]),
            .y(y_o[g]),
            .sof(sof_o[g]),
            .eol(eol_o[g]),
            .drop_cnt(drop_o[g])
        );

        // Model: a queue holds the enable of the last LAT cycles, so the
        // front says whether the cycle now ending carried a pair. Positions
        // are plain counters over an H x V frame.
        bit          running;
        bit          ckeQ[$];
        logic        expCke, expWe, expSof, expEol;
        logic [31:0] expWd;
        int          expX, expY, px, py, expDrop;
        bit          validNow;

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                running = 1'b1;
                expCke  = 1'b0;
                expWe   = 1'b0;
                expSof  = 1'b0;
                expEol  = 1'b0;
                expWd   = '0;
                expX    = 0;
                expY    = 0;
                px      = 0;
                py      = 0;
                expDrop = 0;
                ckeQ.delete();
                for (int i = 0; i < LAT; i++) ckeQ.push_back(1'b0);
            end else begin
                validNow = ckeQ.pop_front();
                ckeQ.push_back(expCke);
                expWe  = 1'b0;
                expSof = 1'b0;
                expEol = 1'b0;
                if (validNow) begin
                    if (lvl != 4'd15) begin
                        expWe  = 1'b1;
                        expWd  = d;
                        expX   = px;
                        expY   = py;
                        expSof = (px == 0) && (py == 0);
                        expEol = (px == H - 2);
                    end else begin
`ifdef VGA_FEED_DROP_CNT_EN
                        if (expDrop < 65535) expDrop++;
`endif
                    end
                    px += 2;
                    if (px == H) begin
                        px = 0;
                        py = (py + 1) % V;
                    end
                end
                if (running && int'(lvl) >= HI) running = 1'b0;
                else if (!running && int'(lvl) <= LO) running = 1'b1;
                expCke = running;
            end
        end

        always @(negedge clk) begin
            checkOutput("cke",      g, 32'(cke_o[g]),  32'(expCke));
            checkOutput("we",       g, 32'(we_o[g]),   32'(expWe));
            checkOutput("wd",       g, wd_o[g],        expWd);
            checkOutput("x",        g, 32'(x_o[g]),    32'(expX));
            checkOutput("y",        g, 32'(y_o[g]),    32'(expY));
            checkOutput("sof",      g, 32'(sof_o[g]),  32'(expSof));
            checkOutput("eol",      g, 32'(eol_o[g]),  32'(expEol));
            checkOutput("drop_cnt", g, 32'(drop_o[g]), 32'(expDrop));
        end
    end

    // Reset held for two cycles, released mid-cycle 0; cycle k below means
    // the interval after the k-th rising edge following release.
    task automatic resetDut();
        applyStimulus(4'd0);
        rst = 1'b0;
        applyStimulus(4'd0);
        applyStimulus(4'd0);
        rst = 1'b1;
    endtask

    // First pair after reset on the lat=1 instance: cke in cycle 1, first
    // write in cycle 3 at the frame origin.
    task automatic checkFirstPair();
        applyStimulus(4'd0);
        checkOutput("pin_cke_cycle1", 0, 32'(cke_o[0]), 32'd1);
        checkOutput("pin_we_cycle1",  0, 32'(we_o[0]),  32'd0);
        applyStimulus(4'd0);
        checkOutput("pin_we_cycle2",  0, 32'(we_o[0]),  32'd0);
        applyStimulus(4'd0);
        checkOutput("pin_we_cycle3",  0, 32'(we_o[0]),  32'd1);
        checkOutput("pin_x_cycle3",   0, 32'(x_o[0]),   32'd0);
        checkOutput("pin_y_cycle3",   0, 32'(y_o[0]),   32'd0);
        checkOutput("pin_sof_cycle3", 0, 32'(sof_o[0]), 32'd1);
    endtask

    initial begin
        int weCount;
        int weAfterFall;
        int ckeHigh;
        bit prevCke;
        int r;
        logic [3:0] lv;

        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        lvl = 4'd0;
        d   = '0;

        // Outputs stay at zero while reset is held.
        repeat (3) applyStimulus(4'd0);
        checkOutput("pin_reset_cke",  0, 32'(cke_o[0]),  32'd0);
        checkOutput("pin_reset_we",   1, 32'(we_o[1]),   32'd0);
        checkOutput("pin_reset_drop", 1, 32'(drop_o[1]), 32'd0);
        applyStimulus(4'd0);
        rst = 1'b1;
        checkFirstPair();

        // Hysteresis: 12 stops, 8 holds, 4 resumes, each one cycle later.
        applyStimulus(4'd12);
        checkOutput("pin_cke_at12", 0, 32'(cke_o[0]), 32'd1);
        applyStimulus(4'd8);
        checkOutput("pin_cke_after12", 0, 32'(cke_o[0]), 32'd0);
        applyStimulus(4'd8);
        checkOutput("pin_cke_at8", 0, 32'(cke_o[0]), 32'd0);
        applyStimulus(4'd4);
        checkOutput("pin_cke_at4", 0, 32'(cke_o[0]), 32'd0);
        applyStimulus(4'd0);
        checkOutput("pin_cke_after4", 0, 32'(cke_o[0]), 32'd1);

        // lat=2: five enable cycles give five writes, two of them landing
        // after the cycle in which cke was already low.
        resetDut();
        weCount = 0;
        weAfterFall = 0;
        ckeHigh = 0;
        prevCke = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            applyStimulus((i == 5) ? 4'd12 : ((i > 5) ? 4'd8 : 4'd0));
            if (cke_o[1]) ckeHigh++;
            if (we_o[1]) begin
                weCount++;
                if (!prevCke) weAfterFall++;
            end
            prevCke = cke_o[1];
        end
        checkOutput("pin_lat2_cke_high",  1, 32'(ckeHigh),     32'd5);
        checkOutput("pin_lat2_we_pulses", 1, 32'(weCount),     32'd5);
        checkOutput("pin_lat2_we_late",   1, 32'(weAfterFall), 32'd2);

        // Full FIFO over cycles 7..9: lat=2 drops three pairs, lat=1 two.
        resetDut();
        for (int i = 1; i <= 17; i++) begin
            applyStimulus((i >= 7 && i <= 9) ? 4'd15 : 4'd0);
        end
`ifdef VGA_FEED_DROP_CNT_EN
        checkOutput("pin_drop_lat2", 1, 32'(drop_o[1]), 32'd3);
        checkOutput("pin_drop_lat1", 0, 32'(drop_o[0]), 32'd2);
`else
        checkOutput("pin_drop_lat2", 1, 32'(drop_o[1]), 32'd0);
        checkOutput("pin_drop_lat1", 0, 32'(drop_o[0]), 32'd0);
`endif

        // Reset with pairs in flight restarts cleanly at the origin.
        applyStimulus(4'd0);
        rst = 1'b0;
        applyStimulus(4'd0);
        rst = 1'b1;
        checkFirstPair();

        // Randomised traffic with occasional resets; checked cycle by cycle.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      lv = 4'($urandom_range(0, 3));
            else if (r < 70) lv = 4'($urandom_range(0, 15));
            else if (r < 85) lv = 4'd15;
            else             lv = 4'($urandom_range(12, 14));
            applyStimulus(lv);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b0;
                repeat ($urandom_range(1, 3)) applyStimulus(4'd0);
                rst = 1'b1;
            end
        end
        applyStimulus(4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
